manchester_frame_tx: RTL and testbench
======================================

// Module: manchester_frame_tx
// PURPOSE
// - Transmit side of the thermostat link: serialises one 192-bit thermostat frame and drives it out Manchester-encoded.
// - Frame fields in order: preamble, type, constant, thermostat_id, room_temp, set_temp, state, tail.
// - Emits a bit clock matching the receiver's recovered clock; used as the loopback source for the decode path.
// PARAMETERS
// - CLKS_PER_HALFBIT  4              clk cycles per Manchester half-bit (>=1)
// - GAP_CLKS          16             minimum idle cycles after a frame before the next is accepted (>=1)
// - PREAMBLE          32'hAAAA_AAAA  frame bits 191..160
// - MSG_TYPE          32'h0001_0001  bits 159..128 (type_1, type_2)
// - CONSTANT          32'hC0DE_0000  bits 127..96
// - TAIL              24'h0000_FF    bits 23..0
// PORTS
// - clk            in   1   system clock
// - rst_n          in   1   reset: synchronous, active-low
// - start_valid    in   1   request to send a frame
// - start_ready    out  1   block idle, can accept a frame
// - thermostat_id  in   32  payload, bits 95..64
// - room_temp      in   16  payload, bits 63..48
// - set_temp       in   16  payload, bits 47..32
// - state          in   8   payload, bits 31..24
// - tx_out         out  1   Manchester line; idles low
// - tx_bit_clk     out  1   high during the second half of every transmitted bit, 0 otherwise
// - busy           out  1   frame or gap in progress
// - done           out  1   one-cycle pulse at end of frame
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state IDLE; start_ready=1; tx_out, tx_bit_clk, busy and done all 0.
// - Reset mid-frame aborts the frame immediately: line low on the next cycle, no done pulse.
// - FSM states: IDLE, SEND, GAP.
// - IDLE: start_ready=1. When start_valid & start_ready at posedge, all payload inputs are latched into a 192-bit shift register and the FSM goes to SEND.
// - Payload input changes after acceptance are ignored.
// - SEND: starts on the cycle after acceptance. Bits go out MSB first (bit 191 first). Each bit is two half-bits of CLKS_PER_HALFBIT cycles each.
// - Encoding is IEEE 802.3: bit 1 = 0 then 1; bit 0 = 1 then 0. tx_out and tx_bit_clk are registered.
// - Counters: divider 0..CLKS_PER_HALFBIT-1, a half flag, and an 8-bit bit index 191..0. There is no wrap: after bit 0's second half the FSM goes to GAP.
// - Frame duration: exactly 384*CLKS_PER_HALFBIT cycles. done=1 on the first GAP cycle.
// - GAP: tx_out=0, busy=1, start_ready=0 for GAP_CLKS cycles, then IDLE.
// - start_valid while busy is ignored, not queued.
// - Accept-to-accept minimum period: 1 + 384*CLKS_PER_HALFBIT + GAP_CLKS cycles.
// - busy = (state != IDLE); start_ready = ~busy.
// CONFIGURATION
// - Macro MANCHESTER_TX_CHECKSUM_EN.
// - Defined: tail bits 23..16 = XOR of the 9 payload bytes (thermostat_id[31:24] .. state), computed at acceptance. Bits 15..0 = TAIL[15:0].
// - Undefined: tail = TAIL unchanged; no checksum logic is built.
// TESTING
// - T1 (H=1, defaults): accept at cycle 0 -> tx_out cycles 1..4 = 0,1,1,0 (bits 1,0); tx_bit_clk = 0,1,0,1.
// - T2 (H=4): accept at cycle 0 -> done exactly at cycle 1537; busy low and start_ready high at cycle 1537+GAP_CLKS.
// - T3: start_valid held high through the frame and gap -> exactly one frame; next accept on the first IDLE cycle; no overlap.
// - T4: rst_n low during bit 100 -> next cycle tx_out=0, busy=0, start_ready=1; done never pulses.
// - T5 (macro on): id=32'h12345678, room=16'h00C8, set=16'h00D2, state=8'h01 -> tail bits 23..16 = 8'h13.
// - T5 (macro off): same payload -> tail byte = 8'h00.
// - T6: loop tx_out into the receive decoder -> recovered thermostat_id, room_temp, set_temp and state equal the transmitted values.

Source files
------------

// File: rtl/manchester_frame_tx_if.sv
// Start handshake and payload bundle for the thermostat-frame Manchester transmitter.
interface manchester_frame_tx_if;
   logic        start_valid;
   logic        start_ready;
   logic [31:0] thermostat_id;
   logic [15:0] room_temp;
   logic [15:0] set_temp;
   logic [7:0]  state;

   modport master (
      output start_valid, thermostat_id, room_temp, set_temp, state,
      input  start_ready
   );

   modport slave (
      input  start_valid, thermostat_id, room_temp, set_temp, state,
      output start_ready
   );
endinterface

// File: rtl/manchester_frame_tx.sv
// Serialises one 192-bit thermostat frame MSB first, IEEE 802.3 Manchester encoded, then holds an idle gap.
// Optional tail checksum byte enabled by macro MANCHESTER_TX_CHECKSUM_EN.
module manchester_frame_tx #(
   parameter int unsigned CLKS_PER_HALFBIT = 4,
   parameter int unsigned GAP_CLKS         = 16,
   parameter logic [31:0] PREAMBLE         = 32'hAAAA_AAAA,
   parameter logic [31:0] MSG_TYPE         = 32'h0001_0001,
   parameter logic [31:0] CONSTANT         = 32'hC0DE_0000,
   parameter logic [23:0] TAIL             = 24'h0000_FF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   manchester_frame_tx_if.slave start_if,
   output logic                 tx_out,
   output logic                 tx_bit_clk,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned FRAME_W = 192;
   localparam int unsigned DIV_W   = (CLKS_PER_HALFBIT > 1) ? $clog2(CLKS_PER_HALFBIT) : 1;
   localparam int unsigned GAP_W   = $clog2(GAP_CLKS + 1);
   localparam int unsigned IDX_W   = 8;

   typedef enum logic [1:0] {IDLE, SEND, GAP} fsm_t;

   fsm_t               fsm_q, fsm_n;
   logic [DIV_W-1:0]   div_q, div_n;
   logic               half_q, half_n;
   logic [IDX_W-1:0]   idx_q, idx_n;
   logic [FRAME_W-1:0] sr_q, sr_n;
   logic [GAP_W-1:0]   gap_q, gap_n;
   logic               tx_out_n, bit_clk_n, done_n;
   logic               accept;
   logic [23:0]        tail;
   logic [FRAME_W-1:0] frame_in;

`ifdef MANCHESTER_TX_CHECKSUM_EN
   // Tail byte carries the XOR of all nine payload bytes.
   assign tail = {start_if.thermostat_id[31:24] ^ start_if.thermostat_id[23:16] ^
                  start_if.thermostat_id[15:8]  ^ start_if.thermostat_id[7:0]   ^
                  start_if.room_temp[15:8]      ^ start_if.room_temp[7:0]       ^
                  start_if.set_temp[15:8]       ^ start_if.set_temp[7:0]        ^
                  start_if.state, TAIL[15:0]};
`else
   assign tail = TAIL;
`endif

   assign frame_in = {PREAMBLE, MSG_TYPE, CONSTANT, start_if.thermostat_id,
                      start_if.room_temp, start_if.set_temp, start_if.state, tail};

   assign accept = start_if.start_valid & start_if.start_ready;

   // Next-state and look-ahead outputs; line values are registered from the next state.
   always_comb begin
      fsm_n  = fsm_q;
      div_n  = div_q;
      half_n = half_q;
      idx_n  = idx_q;
      sr_n   = sr_q;
      gap_n  = gap_q;
      done_n = 1'b0;

      case (fsm_q)
         IDLE: begin
            if (accept) begin
               fsm_n  = SEND;
               sr_n   = frame_in;
               div_n  = '0;
               half_n = 1'b0;
               idx_n  = IDX_W'(FRAME_W - 1);
            end
         end
         SEND: begin
            if (div_q == DIV_W'(CLKS_PER_HALFBIT - 1)) begin
               div_n = '0;
               if (half_q) begin
                  if (idx_q == '0) begin
                     fsm_n  = GAP;
                     gap_n  = '0;
                     done_n = 1'b1;
                  end else begin
                     idx_n  = idx_q - IDX_W'(1);
                     sr_n   = {sr_q[FRAME_W-2:0], 1'b0};
                     half_n = 1'b0;
                  end
               end else begin
                  half_n = 1'b1;
               end
            end else begin
               div_n = div_q + DIV_W'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_W'(GAP_CLKS - 1)) begin
               fsm_n = IDLE;
            end else begin
               gap_n = gap_q + GAP_W'(1);
            end
         end
         default: fsm_n = IDLE;
      endcase

      // Bit 1 is low-then-high, bit 0 is high-then-low.
      tx_out_n  = (fsm_n == SEND) ? (half_n ? sr_n[FRAME_W-1] : ~sr_n[FRAME_W-1]) : 1'b0;
      bit_clk_n = (fsm_n == SEND) & half_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q                <= IDLE;
         div_q                <= '0;
         half_q               <= 1'b0;
         idx_q                <= '0;
         sr_q                 <= '0;
         gap_q                <= '0;
         tx_out               <= 1'b0;
         tx_bit_clk           <= 1'b0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
         start_if.start_ready <= 1'b1;
      end else begin
         fsm_q                <= fsm_n;
         div_q                <= div_n;
         half_q               <= half_n;
         idx_q                <= idx_n;
         sr_q                 <= sr_n;
         gap_q                <= gap_n;
         tx_out               <= tx_out_n;
         tx_bit_clk           <= bit_clk_n;
         busy                 <= (fsm_n != IDLE);
         done                 <= done_n;
         start_if.start_ready <= (fsm_n == IDLE);
      end
   end

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Directed bench for manchester_frame_tx: one instance at one clk per half-bit, one at four.
module tb_manchester_frame_tx;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   manchester_frame_tx_if if1 ();
   manchester_frame_tx_if if4 ();
   logic tx1, bc1, busy1, done1;
   logic tx4, bc4, busy4, done4;

   manchester_frame_tx #(.CLKS_PER_HALFBIT(1), .GAP_CLKS(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_if(if1.slave),
      .tx_out(tx1), .tx_bit_clk(bc1), .busy(busy1), .done(done1)
   );

   manchester_frame_tx #(.CLKS_PER_HALFBIT(4), .GAP_CLKS(16)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start_if(if4.slave),
      .tx_out(tx4), .tx_bit_clk(bc4), .busy(busy4), .done(done4)
   );

   int vectors = 0;
   int miscompares = 0;

`ifdef MANCHESTER_TX_CHECKSUM_EN
   localparam logic [23:0] EXP_TAIL = 24'h13_00FF;
`else
   localparam logic [23:0] EXP_TAIL = 24'h00_00FF;
`endif

   logic         samp [384];
   logic         bcs  [384];
   logic [191:0] rx;
   logic         exp_tx [4];
   logic         exp_bc [4];
   int           k, done_cnt, ready_k, enc_err, bc_err;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_payload1;
      if1.thermostat_id = 32'h1234_5678;
      if1.room_temp     = 16'h00C8;
      if1.set_temp      = 16'h00D2;
      if1.state         = 8'h01;
   endtask

   // Samples are taken 1ns after each posedge; k counts posedges after the accepting edge.
   initial begin
      exp_tx = '{1'b0, 1'b1, 1'b1, 1'b0};
      exp_bc = '{1'b0, 1'b1, 1'b0, 1'b1};
      rst_n = 1'b0;
      if1.start_valid = 1'b0; if1.thermostat_id = '0; if1.room_temp = '0;
      if1.set_temp = '0; if1.state = '0;
      if4.start_valid = 1'b0; if4.thermostat_id = '0; if4.room_temp = '0;
      if4.set_temp = '0; if4.state = '0;
      step; step;

      chk("rst_tx_out", tx1, 0);
      chk("rst_bit_clk", bc1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_start_ready", if1.start_ready, 1);
      chk("rst_start_ready_h4", if4.start_ready, 1);
      rst_n = 1'b1;
      step;

      // T1/T5/T6: one frame at H=1, decoded by the bench; payload scrambled after acceptance.
      load_payload1;
      if1.start_valid = 1'b1;
      step;
      if1.start_valid = 1'b0;
      if1.thermostat_id = 32'hDEAD_BEEF; if1.room_temp = 16'hFFFF;
      if1.set_temp = 16'h5555; if1.state = 8'hAA;
      chk("t1_busy_after_accept", busy1, 1);
      chk("t1_ready_after_accept", if1.start_ready, 0);
      for (int n = 0; n < 384; n++) begin
         samp[n] = tx1;
         bcs[n]  = bc1;
         if (n < 383 && done1 !== 1'b0) chk("t1_done_early", done1, 0);
         step;
      end
      for (int n = 0; n < 4; n++) begin
         chk($sformatf("t1_tx_out_%0d", n + 1), samp[n], exp_tx[n]);
         chk($sformatf("t1_bit_clk_%0d", n + 1), bcs[n], exp_bc[n]);
      end
      chk("t1_done_first_gap", done1, 1);
      chk("t1_line_idle_gap", tx1, 0);
      chk("t1_busy_gap", busy1, 1);

      enc_err = 0;
      bc_err  = 0;
      for (int b = 0; b < 192; b++) begin
         rx[191 - b] = samp[2*b + 1];
         if (samp[2*b] === samp[2*b + 1]) enc_err++;
         if (bcs[2*b] !== 1'b0 || bcs[2*b + 1] !== 1'b1) bc_err++;
      end
      chk("t6_manchester_halves", enc_err, 0);
      chk("t6_bit_clk_pattern", bc_err, 0);
      chk("t6_preamble", rx[191:160], 32'hAAAA_AAAA);
      chk("t6_type", rx[159:128], 32'h0001_0001);
      chk("t6_constant", rx[127:96], 32'hC0DE_0000);
      chk("t6_thermostat_id", rx[95:64], 32'h1234_5678);
      chk("t6_room_temp", rx[63:48], 16'h00C8);
      chk("t6_set_temp", rx[47:32], 16'h00D2);
      chk("t6_state", rx[31:24], 8'h01);
      chk("t5_tail", rx[23:0], EXP_TAIL);

      k = 0;
      while (!if1.start_ready && k < 100) begin
         step;
         k++;
      end
      chk("t1_gap_length", k, 16);
      chk("t1_idle_busy", busy1, 0);

      // T3: start_valid held through the whole frame and gap.
      load_payload1;
      if1.start_valid = 1'b1;
      step;
      done_cnt = 0;
      ready_k  = 0;
      for (int j = 1; j <= 450; j++) begin
         step;
         if (done1 === 1'b1) done_cnt++;
         if (if1.start_ready === 1'b1) begin
            ready_k = j;
            break;
         end
      end
      chk("t3_ready_cycle", ready_k, 400);
      chk("t3_done_count", done_cnt, 1);
      step;
      chk("t3_reaccept_busy", busy1, 1);
      chk("t3_reaccept_ready", if1.start_ready, 0);
      if1.start_valid = 1'b0;

      // T4: reset while bit index 100 is on the line (bit 91 of the frame, half-bits 182/183).
      for (int j = 0; j < 182; j++) step;
      chk("t4_mid_frame_busy", busy1, 1);
      rst_n = 1'b0;
      step;
      chk("t4_rst_tx_out", tx1, 0);
      chk("t4_rst_busy", busy1, 0);
      chk("t4_rst_ready", if1.start_ready, 1);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int j = 0; j < 420; j++) begin
         step;
         if (done1 === 1'b1 || busy1 === 1'b1) done_cnt++;
      end
      chk("t4_no_done_after_abort", done_cnt, 0);

      // T2: H=4 frame timing.
      if4.thermostat_id = 32'hCAFE_0042; if4.room_temp = 16'h0101;
      if4.set_temp = 16'h0202; if4.state = 8'h03;
      if4.start_valid = 1'b1;
      step;
      if4.start_valid = 1'b0;
      k = 0;
      while (done4 !== 1'b1 && k < 3000) begin
         step;
         k++;
      end
      chk("t2_done_cycle", k, 1536);
      step;
      k++;
      chk("t2_done_one_cycle", done4, 0);
      while (busy4 !== 1'b0 && k < 3000) begin
         step;
         k++;
      end
      chk("t2_idle_cycle", k, 1552);
      chk("t2_ready_at_idle", if4.start_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
